// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Build option: ICACHE_FLUSH_EN adds the whole-cache invalidate walk.
package icache_pkg;

    localparam int WDSZ        = 32;
    localparam int AXI_WIDTH   = 64;
    localparam int WNUM        = 32;
    localparam int LNUM        = 16;
    localparam int LINEBITS    = WNUM * WDSZ;
    localparam int WPB         = AXI_WIDTH / WDSZ;
    localparam int ALLOC_BEATS = WNUM / WPB;
    localparam int AXI_SIZE    = $clog2(AXI_WIDTH / 8);
    localparam int LADDRSZ     = $clog2(LNUM);
    localparam int WADDRSZ     = $clog2(WNUM);
    localparam int OFFSZ       = WADDRSZ + 2;
    localparam int TAGSZ       = WDSZ - LADDRSZ - OFFSZ;
    localparam int BEATSZ      = $clog2(ALLOC_BEATS);

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef logic [WDSZ-1:0]    addr_t;
    typedef logic [LADDRSZ-1:0] laddr_t;
    typedef logic [WADDRSZ-1:0] waddr_t;
    typedef logic [TAGSZ-1:0]   tag_t;
    typedef logic [BEATSZ-1:0]  beat_t;

    typedef struct packed {
        tag_t tag;
        logic valid;
        logic dirty;
    } overhead_t;

    localparam int OVHSZ = $bits(overhead_t);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_REFILL,
        S_RESPOND
`ifdef ICACHE_FLUSH_EN
        , S_FLUSH
`endif
    } icache_state_e;

    function automatic tag_t tag_of(input addr_t a);
        return a[WDSZ-1 -: TAGSZ];
    endfunction

    function automatic laddr_t laddr_of(input addr_t a);
        return a[OFFSZ +: LADDRSZ];
    endfunction

    function automatic waddr_t waddr_of(input addr_t a);
        return a[2 +: WADDRSZ];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_word_sel.sv
// Picks one instruction word out of a full cache line.
// Build option: none.
module icache_word_sel
    import icache_pkg::*;
(
    input  logic [LINEBITS-1:0] line,
    input  waddr_t              waddr,
    output logic [WDSZ-1:0]     word
);

    always_comb begin
        word = line[waddr*WDSZ +: WDSZ];
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache sequencer: lookup, hit response, AXI line refill, tag update.
// Build option: ICACHE_FLUSH_EN enables flush_req and the FLUSH walk.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [WDSZ-1:0]     req_addr,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [WDSZ-1:0]     resp_data,
    output logic                resp_err,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic [LADDRSZ-1:0]  ovh_addr,
    output logic                ovh_we,
    output logic [OVHSZ-1:0]    ovh_wdata,
    input  logic [OVHSZ-1:0]    ovh_rdata,
    output logic [LADDRSZ-1:0]  dat_addr,
    output logic [WNUM-1:0]     dat_we,
    output logic [LINEBITS-1:0] dat_wdata,
    input  logic [LINEBITS-1:0] dat_rdata,
    output logic                arvalid,
    input  logic                arready,
    output logic [WDSZ-1:0]     araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                rvalid,
    output logic                rready,
    input  logic [AXI_WIDTH-1:0] rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast
);

    icache_state_e   state_q, state_d;
    addr_t           addr_q, addr_d;
    beat_t           beat_q, beat_d;
    logic [WDSZ-1:0] word_q, word_d;
    logic            err_q, err_d;

    overhead_t       ovh_rd;
    waddr_t          req_w;
    logic            hit;
    logic            beat_err;
    logic            flush_go;
    logic [WDSZ-1:0] hit_word;
    logic [WDSZ-1:0] beat_word;
    logic            unused_bits;

`ifdef ICACHE_FLUSH_EN
    laddr_t fidx_q, fidx_d;
    logic   fpend_q, fpend_d;

    assign flush_go    = flush_req | fpend_q;
    assign unused_bits = ^{req_addr[1:0], ovh_rd.dirty};
`else
    assign flush_go    = 1'b0;
    assign unused_bits = ^{req_addr[1:0], ovh_rd.dirty, flush_req};
`endif

    assign ovh_rd    = overhead_t'(ovh_rdata);
    assign req_w     = waddr_of(addr_q);
    assign hit       = ovh_rd.valid && (ovh_rd.tag == tag_of(addr_q));
    assign beat_err  = (rresp != RESP_OKAY);
    assign beat_word = rdata[(req_w % WPB)*WDSZ +: WDSZ];

    icache_word_sel u_word_sel (
        .line  (dat_rdata),
        .waddr (req_w),
        .word  (hit_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        word_d     = word_q;
        err_d      = err_q;
`ifdef ICACHE_FLUSH_EN
        fidx_d     = fidx_q;
        fpend_d    = fpend_q;
`endif
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        flush_busy = 1'b0;
        ovh_addr   = laddr_of(addr_q);
        ovh_we     = 1'b0;
        ovh_wdata  = '0;
        dat_addr   = laddr_of(addr_q);
        dat_we     = '0;
        dat_wdata  = '0;
        arvalid    = 1'b0;
        araddr     = '0;
        arlen      = '0;
        arsize     = '0;
        arburst    = '0;
        rready     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (flush_go) begin
`ifdef ICACHE_FLUSH_EN
                    state_d = S_FLUSH;
                    fidx_d  = '0;
                    fpend_d = 1'b0;
`endif
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_d   = req_addr;
                        ovh_addr = laddr_of(req_addr);
                        dat_addr = laddr_of(req_addr);
                        state_d  = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_data  = hit_word;
                    state_d    = S_IDLE;
                    if (flush_go) begin
`ifdef ICACHE_FLUSH_EN
                        state_d = S_FLUSH;
                        fidx_d  = '0;
                        fpend_d = 1'b0;
`endif
                    end else begin
                        req_ready = 1'b1;
                        if (req_valid) begin
                            addr_d   = req_addr;
                            ovh_addr = laddr_of(req_addr);
                            dat_addr = laddr_of(req_addr);
                            state_d  = S_LOOKUP;
                        end
                    end
                end else begin
                    state_d = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                arvalid = 1'b1;
                araddr  = {tag_of(addr_q), laddr_of(addr_q), {OFFSZ{1'b0}}};
                arlen   = 8'(ALLOC_BEATS - 1);
                arsize  = 3'(AXI_SIZE);
                arburst = BURST_INCR;
                if (arready) begin
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                rready = 1'b1;
                if (rvalid) begin
                    dat_we    = {{(WNUM-WPB){1'b0}}, {WPB{1'b1}}}
                                << (int'(beat_q) * WPB);
                    dat_wdata = {ALLOC_BEATS{rdata}};
                    if (beat_q == beat_t'(req_w / WPB)) begin
                        word_d = beat_word;
                    end
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    beat_d = rlast ? '0 : beat_q + 1'b1;
                    if (rlast) begin
                        // Tag goes valid only once the whole line landed cleanly.
                        if (!(err_q || beat_err)) begin
                            ovh_we    = 1'b1;
                            ovh_wdata = {tag_of(addr_q), 1'b1, 1'b0};
                        end
                        state_d = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                resp_valid = 1'b1;
                resp_data  = word_q;
                resp_err   = err_q;
                err_d      = 1'b0;
                state_d    = S_IDLE;
            end
`ifdef ICACHE_FLUSH_EN
            S_FLUSH: begin
                flush_busy = 1'b1;
                ovh_we     = 1'b1;
                ovh_addr   = fidx_q;
                fidx_d     = fidx_q + 1'b1;
                if (fidx_q == laddr_t'(LNUM - 1)) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef ICACHE_FLUSH_EN
        // A flush arriving mid-miss waits until the miss has been answered.
        if (flush_req && (state_q == S_MISS_AR || state_q == S_REFILL ||
                          state_q == S_RESPOND ||
                          (state_q == S_LOOKUP && !hit))) begin
            fpend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
`ifdef ICACHE_FLUSH_EN
            fidx_q  <= '0;
            fpend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            err_q   <= err_d;
`ifdef ICACHE_FLUSH_EN
            fidx_q  <= fidx_d;
            fpend_q <= fpend_d;
`endif
        end
    end

    a_rlast_on_last_beat: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == S_REFILL && rvalid)
            |-> (rlast == (beat_q == beat_t'(ALLOC_BEATS - 1)))
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with SRAM and AXI read-slave models.
// Build option: ICACHE_FLUSH_EN selects the flush expectations.
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic [WDSZ-1:0]      req_addr;
    logic                 req_ready;
    logic                 resp_valid;
    logic [WDSZ-1:0]      resp_data;
    logic                 resp_err;
    logic                 flush_req;
    logic                 flush_busy;
    logic [LADDRSZ-1:0]   ovh_addr;
    logic                 ovh_we;
    logic [OVHSZ-1:0]     ovh_wdata;
    logic [OVHSZ-1:0]     ovh_rdata;
    logic [LADDRSZ-1:0]   dat_addr;
    logic [WNUM-1:0]      dat_we;
    logic [LINEBITS-1:0]  dat_wdata;
    logic [LINEBITS-1:0]  dat_rdata;
    logic                 arvalid;
    logic                 arready;
    logic [WDSZ-1:0]      araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 rvalid;
    logic                 rready;
    logic [AXI_WIDTH-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .ovh_addr(ovh_addr), .ovh_we(ovh_we), .ovh_wdata(ovh_wdata),
        .ovh_rdata(ovh_rdata),
        .dat_addr(dat_addr), .dat_we(dat_we), .dat_wdata(dat_wdata),
        .dat_rdata(dat_rdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    // Backing-store content: every word is a function of its byte address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    logic [OVHSZ-1:0]    ovh_mem [LNUM] = '{default: '0};
    logic [LINEBITS-1:0] dat_mem [LNUM];

    always @(posedge clk) begin
        if (ovh_we) ovh_mem[ovh_addr] <= ovh_wdata;
        ovh_rdata <= ovh_mem[ovh_addr];
        for (int w = 0; w < WNUM; w++) begin
            if (dat_we[w]) dat_mem[dat_addr][w*WDSZ +: WDSZ] <= dat_wdata[w*WDSZ +: WDSZ];
        end
        dat_rdata <= dat_mem[dat_addr];
    end

    int          cyc = 0;
    int          err_beat = -1;
    logic        sl_act;
    int          sl_beat;
    logic [31:0] sl_base;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            sl_act  <= 1'b0;
            sl_beat <= 0;
            sl_base <= '0;
        end else begin
            arready <= arvalid && !arready && !sl_act;
            if (arvalid && arready) begin
                sl_act  <= 1'b1;
                sl_beat <= 0;
                sl_base <= araddr;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
                if (rlast) sl_act <= 1'b0;
                else sl_beat <= sl_beat + 1;
            end else if (sl_act && !rvalid && (cyc % 4 != 3)) begin
                rvalid <= 1'b1;
                rdata  <= {pat(sl_base + 32'(8*sl_beat + 4)), pat(sl_base + 32'(8*sl_beat))};
                rresp  <= (sl_beat == err_beat) ? 2'b10 : 2'b00;
                rlast  <= (sl_beat == ALLOC_BEATS - 1);
            end
        end
    end

    int          ar_cnt = 0;
    int          ovh_wr_cnt = 0;
    logic [31:0] last_araddr = '0;
    logic [7:0]  last_arlen = '0;
    logic [2:0]  last_arsize = '0;
    logic [1:0]  last_arburst = '0;
    logic [OVHSZ-1:0] last_ovh = '0;

    always @(posedge clk) begin
        if (rst_n && arvalid && arready) begin
            ar_cnt       <= ar_cnt + 1;
            last_araddr  <= araddr;
            last_arlen   <= arlen;
            last_arsize  <= arsize;
            last_arburst <= arburst;
        end
        if (rst_n && ovh_we) begin
            ovh_wr_cnt <= ovh_wr_cnt + 1;
            last_ovh   <= ovh_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where resp_valid is seen.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                         output logic e, output int lat, output bit to);
        int n;
        to = 1'b0; lat = 0; d = '0; e = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            to = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 400);
        if (!resp_valid) begin
            to = 1'b1;
        end else begin
            lat = n;
            d   = resp_data;
            e   = resp_err;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        int          ebeat;
        bit          err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        bit          to;
        int          ar0;
        int          w0;
        int          n;
        logic [31:0] b2b [3];

        vecs[0] = '{32'h0000_1040, 1'b1, -1, 1'b0};
        vecs[1] = '{32'h0000_1040, 1'b0, -1, 1'b0};
        vecs[2] = '{32'h0000_1044, 1'b0, -1, 1'b0};
        vecs[3] = '{32'h0000_107C, 1'b0, -1, 1'b0};
        vecs[4] = '{32'h0001_1040, 1'b1, -1, 1'b0};
        vecs[5] = '{32'h0000_1040, 1'b1, -1, 1'b0};
        vecs[6] = '{32'h0000_2084, 1'b1,  1, 1'b1};
        vecs[7] = '{32'h0000_2084, 1'b1, -1, 1'b0};
        vecs[8] = '{32'h0000_2088, 1'b0, -1, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_ctrl_outs", 64'({resp_valid, resp_err, arvalid, rready, ovh_we, flush_busy}), 64'd0);
        chk("reset_dat_we", 64'(dat_we), 64'd0);
        chk("reset_ovh_addr", 64'(ovh_addr), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            err_beat = vecs[i].ebeat;
            ar0 = ar_cnt;
            w0  = ovh_wr_cnt;
            fetch(vecs[i].addr, d, e, lat, to);
            chk($sformatf("v%0d_timeout", i), 64'(to), 64'd0);
            chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].err));
            if (!vecs[i].err) chk($sformatf("v%0d_data", i), 64'(d), 64'(pat(vecs[i].addr)));
            chk($sformatf("v%0d_ar_count", i), 64'(ar_cnt - ar0), 64'(vecs[i].miss));
            chk($sformatf("v%0d_ovh_writes", i), 64'(ovh_wr_cnt - w0),
                64'(vecs[i].miss && !vecs[i].err));
            if (vecs[i].miss) begin
                chk($sformatf("v%0d_araddr", i), 64'(last_araddr), 64'(vecs[i].addr & 32'hFFFF_FF80));
            end else begin
                chk($sformatf("v%0d_hit_latency", i), 64'(lat), 64'd1);
            end
            if (i == 0) begin
                chk("ar_fields", 64'({last_arlen, last_arsize, last_arburst}), 64'({8'd15, 3'd3, 2'b01}));
                chk("ovh_wdata_valid", 64'(last_ovh), 64'({21'h2, 1'b1, 1'b0}));
            end
        end
        err_beat = -1;

        @(negedge clk);
        b2b[0] = 32'h0000_1040; b2b[1] = 32'h0000_1044; b2b[2] = 32'h0000_2084;
        ar0 = ar_cnt;
        req_valid = 1'b1;
        req_addr  = b2b[0];
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b%0d_ready", k), 64'(req_ready), 64'd1);
            @(negedge clk);
            chk($sformatf("b2b%0d_resp_valid", k), 64'(resp_valid), 64'd1);
            chk($sformatf("b2b%0d_data", k), 64'(resp_data), 64'(pat(b2b[k])));
            if (k < 2) req_addr = b2b[k+1];
            else req_valid = 1'b0;
        end
        chk("b2b_no_ar", 64'(ar_cnt - ar0), 64'd0);

        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        n = 0;
`ifdef ICACHE_FLUSH_EN
        while (flush_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("flush_busy_cycles", 64'(n), 64'(LNUM));
        ar0 = ar_cnt;
        fetch(32'h0000_1040, d, e, lat, to);
        chk("post_flush_timeout", 64'(to), 64'd0);
        chk("post_flush_miss", 64'(ar_cnt - ar0), 64'd1);
        chk("post_flush_data", 64'(d), 64'(pat(32'h0000_1040)));
`else
        for (int k = 0; k < 20; k++) begin
            if (flush_busy) n++;
            @(negedge clk);
        end
        chk("flush_ignored_busy", 64'(n), 64'd0);
        ar0 = ar_cnt;
        fetch(32'h0000_1040, d, e, lat, to);
        chk("post_flush_timeout", 64'(to), 64'd0);
        chk("post_flush_still_hit", 64'(ar_cnt - ar0), 64'd0);
        chk("post_flush_latency", 64'(lat), 64'd1);
`endif

        @(negedge clk);
        ar0 = ar_cnt;
        w0  = ovh_wr_cnt;
        req_valid = 1'b1;
        req_addr  = 32'h0000_3100;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(rvalid && sl_beat == 2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach_beat2", 64'(rvalid && sl_beat == 2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_ctrl_outs", 64'({rready, arvalid, resp_valid, ovh_we}), 64'd0);
        chk("rst_mid_dat_we", 64'(dat_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_ovh_write", 64'(ovh_wr_cnt - w0), 64'd0);
        ar0 = ar_cnt;
        fetch(32'h0000_3104, d, e, lat, to);
        chk("rst_restart_timeout", 64'(to), 64'd0);
        chk("rst_restart_miss", 64'(ar_cnt - ar0), 64'd1);
        chk("rst_restart_data", 64'(d), 64'(pat(32'h0000_3104)));
        chk("rst_restart_err", 64'(e), 64'd0);
        fetch(32'h0000_3100, d, e, lat, to);
        chk("rst_rehit_latency", 64'(lat), 64'd1);
        chk("rst_rehit_data", 64'(d), 64'(pat(32'h0000_3100)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
